ldly_rcv: RTL and testbench

Level-pulse receiver: the receiving end of the long-delay level outputs (ldlyXus-style, fixed-width levels started by a pulse). It qualifies an incoming level `l` by its width and regenerates single-clock pulses at the qualified leading edge and at the trailing edge. It measures the width and flags runt or overlong levels. It sits on cable and inter-unit inputs where a remote timing chain signals with a level rather than a pulse. One clk period is the simulation time quantum (10 ns).

---
 rtl/ldly_rcv.sv | 133 +++++++++++++
 tb/tb_ldly_rcv.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ldly_rcv.sv
// Level-pulse receiver: qualifies an incoming level by width, regenerates
// leading/trailing pulses and reports runt or overlong levels.
module ldly_rcv #(
   parameter int W    = 8,
   parameter int MINW = 18,
   parameter int MAXW = 0,
   parameter int SYNC = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         l,
   input  logic         clr,
   output logic         p_lead,
   output logic         p_trail,
   output logic         err,
   output logic         lvl,
   output logic         busy,
   output logic [W-1:0] width
);

   typedef enum logic [1:0] {IDLE, QUAL, HOLD, WAIT_LOW} state_t;

   localparam logic [W-1:0] MINW_C = W'(MINW);
   localparam logic [W-1:0] MAXW_C = W'(MAXW);

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic         li;
   state_t       state;
   logic [W-1:0] cnt;
   logic [W-1:0] cnt_inc;

   generate
      if (SYNC != 0) begin : g_sync
         logic l_p0, l_p1;
         // Synchroniser resets to "high" so a level present at reset release
         // keeps the FSM in WAIT_LOW instead of looking like a fresh rise.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               l_p0 <= 1'b1;
               l_p1 <= 1'b1;
            end else begin
               l_p0 <= l;
               l_p1 <= l_p0;
            end
         end
         assign li = l_p1;
      end else begin : g_nosync
         assign li = l;
      end
   endgenerate

   assign cnt_inc = sat_inc(cnt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= WAIT_LOW;
         cnt     <= '0;
         width   <= '0;
         p_lead  <= 1'b0;
         p_trail <= 1'b0;
         err     <= 1'b0;
         lvl     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         p_lead  <= 1'b0;
         p_trail <= 1'b0;
         err     <= 1'b0;
         if (clr) begin
            state <= WAIT_LOW;
            cnt   <= '0;
            lvl   <= 1'b0;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               WAIT_LOW: begin
                  if (!li) state <= IDLE;
               end
               IDLE: begin
                  if (li) begin
                     cnt  <= {{(W-1){1'b0}}, 1'b1};
                     busy <= 1'b1;
                     if (MINW == 1) begin
                        state  <= HOLD;
                        p_lead <= 1'b1;
                        lvl    <= 1'b1;
                     end else begin
                        state <= QUAL;
                     end
                  end
               end
               QUAL: begin
                  if (li) begin
                     cnt <= cnt_inc;
                     if (cnt_inc == MINW_C) begin
                        state  <= HOLD;
                        p_lead <= 1'b1;
                        lvl    <= 1'b1;
                     end
                  end else begin
                     width <= cnt;
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
               HOLD: begin
                  if (li) begin
                     cnt <= cnt_inc;
                     if ((MAXW != 0) && (cnt_inc > MAXW_C)) begin
                        width <= cnt_inc;
                        err   <= 1'b1;
                        lvl   <= 1'b0;
                        busy  <= 1'b0;
                        state <= WAIT_LOW;
                     end
                  end else begin
                     width   <= cnt;
                     p_trail <= 1'b1;
                     lvl     <= 1'b0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end
               end
               default: state <= WAIT_LOW;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ldly_rcv.sv
// Bench for ldly_rcv: three parameterisations share one stimulus stream and
// are checked every cycle against a run-length reference model.
module tb_ldly_rcv;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic l = 1'b1;
   logic clr = 1'b0;

   logic       a_lead, a_trail, a_err, a_lvl, a_busy;
   logic [7:0] a_width;
   logic       b_lead, b_trail, b_err, b_lvl, b_busy;
   logic [7:0] b_width;
   logic       c_lead, c_trail, c_err, c_lvl, c_busy;
   logic [3:0] c_width;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ldly_rcv #(.W(8), .MINW(18), .MAXW(0), .SYNC(0)) dut_a (
      .clk(clk), .reset(reset), .l(l), .clr(clr),
      .p_lead(a_lead), .p_trail(a_trail), .err(a_err),
      .lvl(a_lvl), .busy(a_busy), .width(a_width));

   ldly_rcv #(.W(8), .MINW(4), .MAXW(6), .SYNC(0)) dut_b (
      .clk(clk), .reset(reset), .l(l), .clr(clr),
      .p_lead(b_lead), .p_trail(b_trail), .err(b_err),
      .lvl(b_lvl), .busy(b_busy), .width(b_width));

   ldly_rcv #(.W(4), .MINW(2), .MAXW(0), .SYNC(1)) dut_c (
      .clk(clk), .reset(reset), .l(l), .clr(clr),
      .p_lead(c_lead), .p_trail(c_trail), .err(c_err),
      .lvl(c_lvl), .busy(c_busy), .width(c_width));

   // Reference model: armed = a low has been seen since reset/clr/overlong;
   // run = consecutive high samples of the current level.
   int minw [3] = '{18, 4, 2};
   int maxw [3] = '{0, 6, 0};
   int satv [3] = '{255, 255, 15};
   bit sync [3] = '{1'b0, 1'b0, 1'b1};

   bit armed [3];
   int run   [3];
   int wid   [3];
   bit e_lead [3];
   bit e_trail[3];
   bit e_err  [3];
   bit d1 [3];
   bit d2 [3];

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         armed[i] = 1'b0; run[i] = 0; wid[i] = 0;
         e_lead[i] = 1'b0; e_trail[i] = 1'b0; e_err[i] = 1'b0;
         d1[i] = l; d2[i] = l;
      end
   endfunction

   function automatic void model_step(int i, bit lv, bit cv);
      bit s;
      if (sync[i]) begin
         s = d2[i]; d2[i] = d1[i]; d1[i] = lv;
      end else begin
         s = lv;
      end
      e_lead[i] = 1'b0; e_trail[i] = 1'b0; e_err[i] = 1'b0;
      if (cv) begin
         armed[i] = 1'b0; run[i] = 0;
      end else if (!armed[i]) begin
         if (!s) armed[i] = 1'b1;
      end else if (s) begin
         run[i] = (run[i] < satv[i]) ? run[i] + 1 : satv[i];
         if (run[i] == minw[i]) e_lead[i] = 1'b1;
         if (maxw[i] != 0 && run[i] > maxw[i]) begin
            e_err[i] = 1'b1; wid[i] = run[i]; armed[i] = 1'b0; run[i] = 0;
         end
      end else if (run[i] > 0) begin
         if (run[i] < minw[i]) e_err[i] = 1'b1;
         else                  e_trail[i] = 1'b1;
         wid[i] = run[i];
         run[i] = 0;
      end
   endfunction

   function automatic logic [12:0] exp_vec(int i);
      logic e_lvl, e_busy;
      e_lvl  = armed[i] && (run[i] >= minw[i]);
      e_busy = armed[i] && (run[i] > 0);
      return {e_lead[i], e_trail[i], e_err[i], e_lvl, e_busy, 8'(wid[i])};
   endfunction

   task automatic check_all(input string tag);
      logic [12:0] o [3];
      logic [12:0] e;
      o[0] = {a_lead, a_trail, a_err, a_lvl, a_busy, a_width};
      o[1] = {b_lead, b_trail, b_err, b_lvl, b_busy, b_width};
      o[2] = {c_lead, c_trail, c_err, c_lvl, c_busy, 4'b0000, c_width};
      for (int i = 0; i < 3; i++) begin
         e = exp_vec(i);
         checks++;
         assert (o[i] === e) else begin
            errors++;
            $error("FAIL %s dut%0d {lead,trail,err,lvl,busy,width} observed=%h expected=%h",
                   tag, i, o[i], e);
         end
      end
   endtask

   task automatic cyc(input bit lv, input bit cv, input string tag);
      l   = lv;
      clr = cv;
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i, lv, cv);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic hold(input bit lv, input int n, input string tag);
      repeat (n) cyc(lv, 1'b0, tag);
   endtask

   initial begin
      reset = 1'b1; l = 1'b1; clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all("reset_state");
      reset = 1'b0;

      hold(1'b1, 6, "high_thru_reset");
      hold(1'b0, 3, "first_low");

      hold(1'b1, 20, "accept_hi");
      hold(1'b0, 5, "accept_lo");

      hold(1'b1, 10, "runt_hi");
      hold(1'b0, 5, "runt_lo");

      hold(1'b1, 12, "overlong_hi");
      hold(1'b0, 5, "overlong_lo");

      hold(1'b1, 3, "b2b_hi1");
      hold(1'b0, 1, "b2b_gap");
      hold(1'b1, 3, "b2b_hi2");
      hold(1'b0, 5, "b2b_lo");

      hold(1'b1, 20, "sat_hi");
      hold(1'b0, 5, "sat_lo");

      hold(1'b1, 22, "clr_hi");
      cyc(1'b1, 1'b1, "clr_pulse");
      hold(1'b1, 4, "clr_after");
      hold(1'b0, 5, "clr_lo");

      // Asynchronous reset in the middle of a level, level held through release
      hold(1'b1, 10, "midreset_hi");
      #2 reset = 1'b1;
      model_reset();
      @(negedge clk);
      check_all("midreset_state");
      reset = 1'b0;
      hold(1'b1, 5, "midreset_held");
      hold(1'b0, 4, "midreset_lo");
      hold(1'b1, 20, "midreset_next");
      hold(1'b0, 5, "midreset_next_lo");

      for (int k = 0; k < 30; k++) begin
         int n, m;
         n = $urandom_range(1, 30);
         m = $urandom_range(1, 4);
         for (int j = 0; j < n; j++)
            cyc(1'b1, ($urandom_range(0, 40) == 0), "rand_hi");
         hold(1'b0, m, "rand_lo");
      end
      hold(1'b0, 4, "final_lo");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
